// File: rtl/axi4_lite_timer_slave_pkg.sv
// Shared constants, state encodings and helpers
// for the AXI4-Lite timer peripheral.
package axi4_lite_timer_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] REG_LED  = 2'd0;
  localparam logic [1:0] REG_CNT  = 2'd1;
  localparam logic [1:0] REG_CMP  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_MATCH  = 8;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] m;
    m = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) m[8*b +: 8] = new_v[8*b +: 8];
    return m;
  endfunction

endpackage

// File: rtl/axi4_lite_timer_slave_core.sv
// Timer register file: LED, counter, compare,
// control/status with sticky match and level irq.
module axi4_lite_timer_core
  import axi4_lite_timer_slave_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [1:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic [1:0]  i_raddr,
  output logic [31:0] o_rdata,
  output logic        o_led,
  output logic        o_irq
);

  logic        r_led;
  logic        r_en;
  logic        r_irq_en;
  logic        r_match;
  logic [31:0] r_cnt;
  logic [31:0] r_cmp;
  logic        w_hit;
  logic        w_w1c;

  assign w_hit = r_en && (r_cnt == r_cmp);
  assign w_w1c = i_we && (i_waddr == REG_CTRL)
              && i_wstrb[1] && i_wdata[CTRL_MATCH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led    <= 1'b0;
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_match  <= 1'b0;
      r_cnt    <= '0;
      r_cmp    <= '0;
    end else begin
      if (i_we && i_waddr == REG_LED && i_wstrb[0])
        r_led <= i_wdata[0];
      // a bus load beats the running increment
      if (i_we && i_waddr == REG_CNT)
        r_cnt <= strb_merge(r_cnt, i_wdata, i_wstrb);
      else if (r_en)
        r_cnt <= r_cnt + 32'd1;
      if (i_we && i_waddr == REG_CMP)
        r_cmp <= strb_merge(r_cmp, i_wdata, i_wstrb);
      if (i_we && i_waddr == REG_CTRL && i_wstrb[0]) begin
        r_en     <= i_wdata[CTRL_EN];
        r_irq_en <= i_wdata[CTRL_IRQ_EN];
      end
      if (w_hit)
        r_match <= 1'b1;
      else if (w_w1c)
        r_match <= 1'b0;
    end
  end

  always_comb begin
    o_rdata = '0;
    unique case (i_raddr)
      REG_LED:  o_rdata[0] = r_led;
      REG_CNT:  o_rdata = r_cnt;
      REG_CMP:  o_rdata = r_cmp;
      REG_CTRL: begin
        o_rdata[CTRL_EN]     = r_en;
        o_rdata[CTRL_IRQ_EN] = r_irq_en;
        o_rdata[CTRL_MATCH]  = r_match;
      end
    endcase
  end

  assign o_led = r_led;
  assign o_irq = r_match & r_irq_en;

endmodule

// File: rtl/axi4_lite_timer_slave.sv
// AXI4-Lite responder: write/read channel FSMs and
// address decode in front of the timer core.
module axi4_lite_timer_slave
  import axi4_lite_timer_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  led,
  output logic                  irq
);

  w_state_t              r_wstate;
  r_state_t              r_rstate;
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_fire;
  logic                  w_w_fire;
  logic                  w_ar_fire;
  logic                  w_have_aw;
  logic                  w_have_w;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wd;
  logic [3:0]            w_ws;
  logic                  w_wok;
  logic                  w_rok;
  logic [31:0]           w_core_rdata;
  logic                  w_unused;

  assign w_aw_fire = awvalid & r_awready;
  assign w_w_fire  = wvalid & r_wready;
  assign w_ar_fire = arvalid & r_arready;
  assign w_have_aw = r_aw_held | w_aw_fire;
  assign w_have_w  = r_w_held | w_w_fire;
  assign w_commit  = (r_wstate == W_IDLE)
                   & w_have_aw & w_have_w;

  // the second half to arrive is used straight off the bus
  assign w_waddr = r_aw_held ? r_awaddr : awaddr;
  assign w_wd    = r_w_held ? r_wdata : wdata;
  assign w_ws    = r_w_held ? r_wstrb : wstrb;

  assign w_wok = w_waddr[ADDR_WIDTH-1:4]
              == BASE_ADDR[ADDR_WIDTH-1:4];
  assign w_rok = araddr[ADDR_WIDTH-1:4]
              == BASE_ADDR[ADDR_WIDTH-1:4];

  assign w_unused = &{1'b0, w_waddr[1:0], araddr[1:0]};

  axi4_lite_timer_core u_core (
    .clk     (clk),
    .rst_n   (rst),
    .i_we    (w_commit & w_wok),
    .i_waddr (w_waddr[3:2]),
    .i_wdata (w_wd),
    .i_wstrb (w_ws),
    .i_raddr (araddr[3:2]),
    .o_rdata (w_core_rdata),
    .o_led   (led),
    .o_irq   (irq)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          if (w_aw_fire) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= awaddr;
          end
          if (w_w_fire) begin
            r_w_held <= 1'b1;
            r_wdata  <= wdata;
            r_wstrb  <= wstrb;
          end
          if (w_commit) begin
            r_wstate  <= W_RESP;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wok ? RESP_OKAY : RESP_SLVERR;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
          end else begin
            r_awready <= ~w_have_aw;
            r_wready  <= ~w_have_w;
          end
        end
        W_RESP: begin
          if (bready) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (w_ar_fire) begin
            r_rstate  <= R_RESP;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rok ? w_core_rdata : '0;
            r_rresp   <= w_rok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (rready) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

endmodule

// File: tb/tb_axi4_lite_timer_slave.sv
// Randomized bench for the AXI4-Lite timer slave,
// checked against a cycle-indexed arithmetic model.
module tb_axi4_lite_timer_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        led;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  axi4_lite_timer_slave dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid),
    .bready(bready), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready), .led(led), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: counter is base + elapsed cycles since t0
  // while enabled; match is scanned lazily per cycle.
  logic        m_led;
  logic        m_en;
  logic        m_ie;
  logic        m_match;
  logic [31:0] m_cmp;
  logic [31:0] m_base;
  int          m_t0;
  int          m_mt;

  function automatic bit in_range(input logic [31:0] a);
    return a[31:4] == 28'h400_0000;
  endfunction

  function automatic logic [31:0] cnt_at(input int k);
    return m_en ? m_base + 32'(k - m_t0) : m_base;
  endfunction

  function automatic logic [31:0] bmerge(
    input logic [31:0] o, d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (d & mask);
  endfunction

  task automatic settle(input int k);
    for (int c = m_mt; c < k; c++)
      if (m_en && cnt_at(c) == m_cmp) m_match = 1'b1;
    if (k > m_mt) m_mt = k;
  endtask

  task automatic m_reset();
    m_led = 0; m_en = 0; m_ie = 0; m_match = 0;
    m_cmp = '0; m_base = '0; m_t0 = cyc; m_mt = cyc;
  endtask

  // Write committed at clock edge e.
  task automatic m_write(input logic [31:0] a, d,
                         input logic [3:0] s, input int e);
    bit hit;
    if (!in_range(a)) return;
    settle(e - 1);
    hit = m_en && cnt_at(e - 1) == m_cmp;
    case (a[3:2])
      2'd0: if (s[0]) m_led = d[0];
      2'd1: begin
        m_base = bmerge(cnt_at(e - 1), d, s);
        m_t0 = e;
      end
      2'd2: m_cmp = bmerge(m_cmp, d, s);
      default: begin
        if (s[0]) begin
          m_base = cnt_at(e); m_t0 = e;
          m_en = d[0]; m_ie = d[1];
        end
        if (s[1] && d[8]) m_match = 1'b0;
      end
    endcase
    if (hit) m_match = 1'b1;
    m_mt = e;
  endtask

  // Register contents visible during cycle k.
  task automatic m_read(input logic [31:0] a, input int k,
                        output logic [31:0] d);
    settle(k);
    d = '0;
    if (!in_range(a)) return;
    case (a[3:2])
      2'd0: d = {31'd0, m_led};
      2'd1: d = cnt_at(k);
      2'd2: d = m_cmp;
      default: d = {23'd0, m_match, 6'd0, m_ie, m_en};
    endcase
  endtask

  task automatic irq_at(input int k, output logic v);
    settle(k);
    v = m_match & m_ie;
  endtask

  task automatic axi_write(input logic [31:0] a, d,
                           input logic [3:0] s,
                           input int awd, wd, bd);
    bit aw_done, w_done, hs_aw, hs_w;
    int n;
    logic [1:0] xr;
    aw_done = 0; w_done = 0; n = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && n < 40) begin
      awvalid = !aw_done && n >= awd;
      wvalid  = !w_done && n >= wd;
      @(negedge clk);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk); #1;
      aw_done |= hs_aw; w_done |= hs_w; n++;
    end
    awvalid = 0; wvalid = 0;
    chk("w_hs", 32'({aw_done, w_done}), 32'd3);
    xr = in_range(a) ? 2'b00 : 2'b10;
    m_write(a, d, s, cyc);
    chk("bvalid", 32'(bvalid), 32'd1);
    repeat (bd) begin
      chk("b_stall", 32'({bresp, bvalid, awready, wready}),
          32'({xr, 3'b100}));
      @(posedge clk); #1;
    end
    chk("bresp", 32'(bresp), 32'(xr));
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    chk("b_done", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int rd,
                          input bit pre, input logic [31:0] pexp);
    bit hs;
    int n;
    logic [31:0] xd;
    logic [1:0] xr;
    hs = 0; n = 0;
    araddr = a; arvalid = 1;
    while (!hs && n < 40) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
      n++;
    end
    arvalid = 0;
    chk("ar_hs", 32'(hs), 32'd1);
    if (pre) xd = pexp;
    else m_read(a, cyc - 1, xd);
    xr = in_range(a) ? 2'b00 : 2'b10;
    chk("rvalid", 32'(rvalid), 32'd1);
    repeat (rd) begin
      chk("r_stall", 32'({rvalid, arready}), 32'd2);
      chk("r_stall_d", rdata, xd);
      @(posedge clk); #1;
    end
    chk("rdata", rdata, xd);
    chk("rresp", 32'(rresp), 32'(xr));
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    chk("r_done", 32'(rvalid), 32'd0);
  endtask

  task automatic wait_cyc(input int k);
    int n;
    n = 0;
    while (cyc < k && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_cyc", 32'(cyc), 32'(k));
  endtask

  logic [31:0] ta, td;
  logic [3:0]  ts;
  logic        xirq;
  int          k0;

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 32'({awready, wready, arready, bvalid,
        rvalid, led, irq, bresp, rresp}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1;
    m_reset();
    @(posedge clk); #1;
    chk("rdy_rise", 32'({awready, wready, arready}), 32'd7);

    // reset while an address is latched
    awaddr = 32'h4000_0000; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    chk("aw_held", 32'({awready, wready}), 32'd1);
    rst = 0; #1;
    chk("mid_rst", 32'({awready, bvalid}), 32'd0);
    @(posedge clk); #1;
    rst = 1;
    m_reset();
    @(posedge clk); #1;
    chk("aw_drop", 32'({awready, wready}), 32'd3);

    // AW first, W three cycles later
    axi_write(32'h4000_0000, 32'd1, 4'hF, 0, 3, 0);
    chk("led", 32'(led), 32'(m_led));
    axi_read(32'h4000_0000, 0, 0, 0);

    // counter wrap
    axi_write(32'h4000_0004, 32'hFFFF_FFFE, 4'hF, 1, 0, 0);
    axi_write(32'h4000_000C, 32'h1, 4'hF, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    axi_read(32'h4000_0004, 0, 0, 0);

    // compare match and W1C
    axi_write(32'h4000_000C, 32'h100, 4'hF, 0, 0, 0);
    axi_write(32'h4000_0008, 32'd10, 4'hF, 0, 0, 0);
    axi_write(32'h4000_0004, 32'd0, 4'hF, 0, 0, 0);
    axi_write(32'h4000_000C, 32'h3, 4'hF, 0, 0, 0);
    k0 = m_t0 + int'(m_cmp - m_base);
    wait_cyc(k0);
    irq_at(cyc, xirq);
    chk("irq_pre", 32'(irq), 32'(xirq));
    @(posedge clk); #1;
    irq_at(cyc, xirq);
    chk("irq_set", 32'(irq), 32'(xirq));
    axi_write(32'h4000_000C, 32'h103, 4'h3, 0, 0, 0);
    irq_at(cyc, xirq);
    chk("irq_clr", 32'(irq), 32'(xirq));
    axi_read(32'h4000_000C, 1, 0, 0);

    // byte-strobed compare write
    axi_write(32'h4000_0008, 32'h1122_3344, 4'hF, 0, 0, 0);
    axi_write(32'h4000_0008, 32'h0000_AB00, 4'h2, 2, 1, 0);
    axi_read(32'h4000_0008, 0, 0, 0);

    // decode errors
    axi_read(32'h4000_0010, 0, 0, 0);
    axi_write(32'h5000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 1);
    axi_read(32'h4000_0000, 0, 0, 0);
    axi_read(32'h4000_0008, 0, 0, 0);

    // read completes while B is stalled
    fork
      axi_write(32'h4000_0000, 32'd0, 4'h1, 0, 0, 5);
      begin
        repeat (2) @(posedge clk);
        #1;
        axi_read(32'h4000_0000, 0, 0, 0);
      end
    join

    // same-cycle read and write sees the old value
    td = {31'd0, m_led};
    fork
      axi_write(32'h4000_0000, 32'd1, 4'hF, 0, 0, 0);
      axi_read(32'h4000_0000, 0, 1, td);
    join
    chk("led_new", 32'(led), 32'(m_led));

    for (int i = 0; i < 30; i++) begin
      ta = 32'h4000_0000 | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) ta = $urandom;
      td = $urandom;
      ts = 4'($urandom_range(0, 15));
      axi_write(ta, td, ts, $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 2));
      ta = 32'h4000_0000 | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0)
        ta = 32'h4000_0010 + 32'($urandom_range(0, 255));
      axi_read(ta, $urandom_range(0, 2), 0, 0);
      irq_at(cyc, xirq);
      chk("irq_rnd", 32'(irq), 32'(xirq));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
